// File: rtl/clipq_weight_packer_pkg.sv
// ============================================================================
// Module      : clipq_weight_packer_pkg
// Description : Shared definitions for the ClipQ weight packer: SRAM write
//               request encodings, packing geometry, packed word type and
//               the packer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CLIPQ_WRITE_REQ_DEFS
`define CLIPQ_WRITE_REQ_DEFS
`define WRITE_ENB 1'b1
`define WRITE_DIS 1'b0
`endif

package clipq_weight_packer_pkg;

    // Weights per packed SRAM word and bits per codebook index
    localparam int GROUP  = 9;
    localparam int IDX_W  = 2;
    localparam int PACK_W = GROUP * IDX_W;

    // One packed word: index i lives at bits [2i+1:2i]
    typedef logic [PACK_W-1:0] packed_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sp_ram_intf.sv
// ============================================================================
// Module      : sp_ram_intf
// Description : Single-port SRAM access bundle; the compute side drives the
//               chip select, output enable, write request, address and data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sp_ram_intf;
    logic        cs;
    logic        oe;
    logic        W_req;
    logic [31:0] addr;
    logic [31:0] W_data;

    modport compute (
        output cs,
        output oe,
        output W_req,
        output addr,
        output W_data
    );
endinterface

`default_nettype wire

// File: rtl/clipq_quant_enc.sv
// ============================================================================
// Module      : clipq_quant_enc
// Description : Combinational ClipQ quantizer. Maps a signed 8-bit weight to
//               the index of the nearest of four signed 8-bit codebook
//               levels; equal distances resolve to the lowest index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clipq_quant_enc (
    input  logic [7:0]  weight,
    input  logic [31:0] w8,
    output logic [1:0]  idx
);

    // Distances are magnitudes of a 9-bit signed difference, so at most 255
    logic [8:0] w_dist [4];

    for (genvar k = 0; k < 4; k++) begin : g_dist
        logic signed [8:0] w_diff;
        assign w_diff    = $signed({weight[7], weight}) - $signed({w8[8*k+7], w8[8*k +: 8]});
        assign w_dist[k] = w_diff[8] ? 9'(-w_diff) : 9'(w_diff);
    end

    // Argmin scan; strict less-than keeps the lowest index on ties
    always_comb begin
        logic [8:0] w_best;
        idx    = 2'd0;
        w_best = w_dist[0];
        for (int k = 1; k < 4; k++) begin
            if (w_dist[k] < w_best) begin
                w_best = w_dist[k];
                idx    = 2'(k);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/clipq_weight_packer.sv
// ============================================================================
// Module      : clipq_weight_packer
// Description : Quantizes a stream of signed 8-bit weights to 2-bit ClipQ
//               codebook indices, packs nine per 18-bit word and writes the
//               words to consecutive weight SRAM addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clipq_weight_packer
    import clipq_weight_packer_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] w8,
    input  logic [31:0] num_words,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        busy,
    output logic        finish,
    sp_ram_intf.compute weight_intf
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_w8;
    logic [31:0]        r_num_words;
    logic [31:0]        r_word_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic [3:0]         r_lane;
    packed_word_t       r_packed;

    logic [IDX_W-1:0]   w_idx;
    logic               w_hs;
    logic               w_last_lane;
    logic               w_last_word;
    logic               w_cs;
    logic               w_wreq;
    logic [31:0]        w_wdata;

    clipq_quant_enc u_quant_enc (
        .weight (in_data),
        .w8     (r_w8),
        .idx    (w_idx)
    );

    assign w_hs        = in_valid && (r_state == ENC);
    assign w_last_lane = (r_lane == 4'(GROUP - 1));
    assign w_last_word = (r_word_cnt == (r_num_words - 32'd1));

    assign weight_intf.cs     = w_cs;
    assign weight_intf.oe     = 1'b1;
    assign weight_intf.W_req  = w_wreq;
    assign weight_intf.addr   = 32'(r_addr);
    assign weight_intf.W_data = w_wdata;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-state outputs; the SRAM strobe exists only in WR
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        finish      = 1'b0;
        w_cs        = 1'b0;
        w_wreq      = `WRITE_DIS;
        w_wdata     = 32'd0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (num_words == 32'd0) ? FIN : ENC;
                end
            end
            ENC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_hs && w_last_lane) begin
                    w_state_nxt = WR;
                end
            end
            WR: begin
                busy        = 1'b1;
                w_cs        = 1'b1;
                w_wreq      = `WRITE_ENB;
                w_wdata     = {{(32-PACK_W){1'b0}}, r_packed};
                w_state_nxt = w_last_word ? FIN : ENC;
            end
            FIN: begin
                busy        = 1'b1;
                finish      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Job setup, lane packing and address/word bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w8        <= 32'd0;
            r_num_words <= 32'd0;
            r_word_cnt  <= 32'd0;
            r_addr      <= '0;
            r_lane      <= 4'd0;
            r_packed    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_w8        <= w8;
                        r_num_words <= num_words;
                        r_word_cnt  <= 32'd0;
                        r_addr      <= '0;
                        r_lane      <= 4'd0;
                        r_packed    <= '0;
                    end
                end
                ENC: begin
                    if (w_hs) begin
                        r_packed[IDX_W*r_lane +: IDX_W] <= w_idx;
                        r_lane <= w_last_lane ? 4'd0 : r_lane + 4'd1;
                    end
                end
                WR: begin
                    // Address wraps naturally at 2^ADDR_W
                    r_addr     <= r_addr + 1'b1;
                    r_word_cnt <= r_word_cnt + 32'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clipq_weight_packer.sv
// ============================================================================
// Module      : tb_clipq_weight_packer
// Description : Directed self-checking bench for clipq_weight_packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef CLIPQ_WRITE_REQ_DEFS
`define CLIPQ_WRITE_REQ_DEFS
`define WRITE_ENB 1'b1
`define WRITE_DIS 1'b0
`endif

module tb_clipq_weight_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] w8;
    logic [31:0] num_words;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        busy;
    logic        finish;

    sp_ram_intf ram_if ();

    clipq_weight_packer #(.ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .w8          (w8),
        .num_words   (num_words),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .busy        (busy),
        .finish      (finish),
        .weight_intf (ram_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Write log and event counters, sampled mid-cycle
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int fin_cnt   = 0;
    int wr_bad    = 0;
    int rdy_seen  = 0;

    logic [7:0] wv [0:26];

    always @(negedge clk) begin
        if (ram_if.cs === 1'b1) begin
            wr_addr_q.push_back(ram_if.addr);
            wr_data_q.push_back(ram_if.W_data);
            if (in_ready !== 1'b0 || ram_if.W_req !== `WRITE_ENB) wr_bad++;
        end
        if (finish === 1'b1) fin_cnt++;
        if (in_ready === 1'b1) rdy_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        fin_cnt  = 0;
        wr_bad   = 0;
        rdy_seen = 0;
    endtask

    // Nine weights given as {w8,...,w0}
    task automatic load_word(input int base, input logic [71:0] v);
        for (int i = 0; i < 9; i++) wv[base+i] = v[8*i +: 8];
    endtask

    task automatic do_start(input logic [31:0] cb, input logic [31:0] n);
        w8 = cb; num_words = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Streams n weights from wv; optionally stalls and optionally pulses a
    // second start (with codebook pw8) when weight pulse_at is offered
    task automatic send_stream(input int n, input bit stall, input int pulse_at,
                               input logic [31:0] pw8, output bit timed_out);
        int sent = 0;
        int guard = 0;
        bit pulsed = 0;
        timed_out = 0;
        while (sent < n) begin
            if (stall && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = wv[sent];
            end
            if (sent == pulse_at && !pulsed) begin
                start = 1'b1; w8 = pw8; num_words = 32'd5; pulsed = 1;
            end else begin
                start = 1'b0;
            end
            if (in_valid && in_ready) sent++;
            @(negedge clk);
            guard++;
            if (guard > 600) begin
                timed_out = 1;
                break;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_idle(output bit timed_out);
        int guard = 0;
        timed_out = 0;
        while (busy === 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                timed_out = 1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        w8 = 32'd0; num_words = 32'd0;
        @(negedge clk); @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++; if (finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish: got %b required 0", finish); end
        n_checks++; if (ram_if.cs !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b required 0", ram_if.cs); end
        n_checks++; if (ram_if.W_req !== `WRITE_DIS) begin n_fail++; $display("FAIL reset_wreq: got %b required %b", ram_if.W_req, `WRITE_DIS); end
        n_checks++; if (ram_if.addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr: got %h required 0", ram_if.addr); end
        n_checks++; if (ram_if.W_data !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %h required 0", ram_if.W_data); end
        rst = 1'b0;
        @(negedge clk);
        clear_log();
    endtask

    task automatic test_basic_pack();
        bit to;
        clear_log();
        load_word(0, 72'h807F28D8004010F0C0);
        do_start(32'h4010F0C0, 32'd1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", busy); end
        send_stream(9, 0, -1, 32'd0, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL basic_stream_timeout: got timeout required 9 handshakes"); end
        // Cycle after the 9th handshake: the write
        n_checks++; if (ram_if.cs !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_wr_cycle: got cs=%b in_ready=%b required cs=1 in_ready=0", ram_if.cs, in_ready); end
        n_checks++; if (ram_if.addr !== 32'd0 || ram_if.W_data !== 32'h0000E1E4) begin n_fail++; $display("FAIL basic_wr_word: got addr=%h data=%h required addr=0 data=0000e1e4", ram_if.addr, ram_if.W_data); end
        @(negedge clk);
        n_checks++; if (finish !== 1'b1 || ram_if.cs !== 1'b0) begin n_fail++; $display("FAIL basic_finish_timing: got finish=%b cs=%b required finish=1 cs=0", finish, ram_if.cs); end
        @(negedge clk);
        n_checks++; if (finish !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done: got finish=%b busy=%b required 0 0", finish, busy); end
        n_checks++; if (wr_addr_q.size() != 1 || fin_cnt != 1) begin n_fail++; $display("FAIL basic_counts: got writes=%0d finishes=%0d required 1 1", wr_addr_q.size(), fin_cnt); end
    endtask

    task automatic test_multi_word_stalls();
        bit to;
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h0000E1E4; exp_d[1] = 32'h0003FFFF; exp_d[2] = 32'h00013939;
        clear_log();
        load_word(0,  72'h807F28D8004010F0C0);
        load_word(9,  72'h404040404040404040);
        load_word(18, 72'hF0C04010F0C04010F0);
        do_start(32'h4010F0C0, 32'd3);
        send_stream(27, 1, -1, 32'd0, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL multi_stream_timeout: got timeout required 27 handshakes"); end
        wait_idle(to);
        n_checks++; if (to) begin n_fail++; $display("FAIL multi_idle_timeout: got busy stuck required idle"); end
        n_checks++; if (wr_addr_q.size() != 3) begin n_fail++; $display("FAIL multi_write_count: got %0d required 3", wr_addr_q.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < wr_addr_q.size()) begin
                n_checks++; if (wr_addr_q[i] !== 32'(i) || wr_data_q[i] !== exp_d[i]) begin n_fail++; $display("FAIL multi_word%0d: got addr=%h data=%h required addr=%h data=%h", i, wr_addr_q[i], wr_data_q[i], i, exp_d[i]); end
            end
        end
        n_checks++; if (wr_bad != 0) begin n_fail++; $display("FAIL multi_wr_ready: got %0d bad write cycles required 0", wr_bad); end
        n_checks++; if (fin_cnt != 1) begin n_fail++; $display("FAIL multi_finish_count: got %0d required 1", fin_cnt); end
    endtask

    task automatic test_tie_unordered();
        bit to;
        clear_log();
        load_word(0, 72'h404040404040E02008);
        do_start(32'h10C04000, 32'd1);
        send_stream(9, 0, -1, 32'd0, to);
        wait_idle(to);
        n_checks++; if (wr_data_q.size() != 1) begin n_fail++; $display("FAIL tie_write_count: got %0d required 1", wr_data_q.size()); end
        else begin
            n_checks++; if (wr_data_q[0] !== 32'h0001554C) begin n_fail++; $display("FAIL tie_word: got %h required 0001554c", wr_data_q[0]); end
            n_checks++; if (wr_data_q[0][1:0] !== 2'd0 || wr_data_q[0][3:2] !== 2'd3) begin n_fail++; $display("FAIL tie_first_two: got %0d,%0d required 0,3", wr_data_q[0][1:0], wr_data_q[0][3:2]); end
            n_checks++; if (wr_data_q[0][5:4] !== 2'd0) begin n_fail++; $display("FAIL tie_minus32: got %0d required 0", wr_data_q[0][5:4]); end
        end
    endtask

    task automatic test_zero_words();
        int first_fin = -1;
        clear_log();
        do_start(32'h4010F0C0, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            if (finish === 1'b1 && first_fin < 0) first_fin = c;
            @(negedge clk);
        end
        n_checks++; if (first_fin < 1 || first_fin > 2) begin n_fail++; $display("FAIL zero_finish_timing: got cycle %0d required 1..2", first_fin); end
        n_checks++; if (fin_cnt != 1) begin n_fail++; $display("FAIL zero_finish_count: got %0d required 1", fin_cnt); end
        n_checks++; if (wr_addr_q.size() != 0 || rdy_seen != 0) begin n_fail++; $display("FAIL zero_activity: got writes=%0d ready_cycles=%0d required 0 0", wr_addr_q.size(), rdy_seen); end
    endtask

    task automatic test_start_busy();
        bit to;
        clear_log();
        load_word(0, 72'h807F28D8004010F0C0);
        do_start(32'h4010F0C0, 32'd1);
        send_stream(9, 0, 3, 32'h10C04000, to);
        wait_idle(to);
        repeat (3) @(negedge clk);
        n_checks++; if (wr_data_q.size() != 1) begin n_fail++; $display("FAIL busy_write_count: got %0d required 1", wr_data_q.size()); end
        else begin
            n_checks++; if (wr_data_q[0] !== 32'h0000E1E4 || wr_addr_q[0] !== 32'd0) begin n_fail++; $display("FAIL busy_codebook: got addr=%h data=%h required addr=0 data=0000e1e4", wr_addr_q[0], wr_data_q[0]); end
        end
        n_checks++; if (busy !== 1'b0 || fin_cnt != 1) begin n_fail++; $display("FAIL busy_no_restart: got busy=%b finishes=%0d required 0 1", busy, fin_cnt); end
    endtask

    task automatic test_reset_mid_job();
        bit to;
        clear_log();
        load_word(0, 72'h807F28D8004010F0C0);
        load_word(9, 72'h404040404040404040);
        do_start(32'h4010F0C0, 32'd2);
        send_stream(14, 0, -1, 32'd0, to);
        n_checks++; if (ram_if.addr !== 32'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got addr=%h busy=%b required 1 1", ram_if.addr, busy); end
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b0 || busy !== 1'b0 || finish !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got in_ready=%b busy=%b finish=%b required 0 0 0", in_ready, busy, finish); end
        n_checks++; if (ram_if.cs !== 1'b0 || ram_if.W_req !== `WRITE_DIS) begin n_fail++; $display("FAIL rstmid_strobe: got cs=%b wreq=%b required 0 %b", ram_if.cs, ram_if.W_req, `WRITE_DIS); end
        n_checks++; if (ram_if.addr !== 32'd0 || ram_if.W_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_bus: got addr=%h data=%h required 0 0", ram_if.addr, ram_if.W_data); end
        @(negedge clk); @(negedge clk);
        n_checks++; if (wr_addr_q.size() != 1) begin n_fail++; $display("FAIL rstmid_no_partial: got %0d writes required 1", wr_addr_q.size()); end
        rst = 1'b0;
        @(negedge clk);
        clear_log();
        do_start(32'h4010F0C0, 32'd1);
        send_stream(9, 0, -1, 32'd0, to);
        wait_idle(to);
        n_checks++; if (wr_addr_q.size() != 1) begin n_fail++; $display("FAIL rstmid_fresh_count: got %0d required 1", wr_addr_q.size()); end
        else begin
            n_checks++; if (wr_addr_q[0] !== 32'd0 || wr_data_q[0] !== 32'h0000E1E4) begin n_fail++; $display("FAIL rstmid_fresh_word: got addr=%h data=%h required 0 0000e1e4", wr_addr_q[0], wr_data_q[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_pack();
        test_multi_word_stalls();
        test_tie_unordered();
        test_zero_words();
        test_start_busy();
        test_reset_mid_job();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
